// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming encoder scheduler.
//   DATA_W        - nibble width presented to the encoder
//   CODE_W        - codeword width returned by the encoder
//   DEF_BURST_LEN - default number of words issued between encoder resets
//   state_t       - scheduler FSM states
package hamming_pkg;

    localparam int unsigned DATA_W        = 4;
    localparam int unsigned CODE_W        = 7;
    localparam int unsigned DEF_BURST_LEN = 7;

    typedef enum logic [2:0] {
        ENC_RST,
        IDLE,
        ISSUE,
        CAPTURE,
        DELIVER
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req - request vector
//   ptr - index of the most recently served requester; search starts after it
//   en  - grant enable; no grant when low
//   gnt - one-hot grant
//   idx - binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int unsigned   j;
    logic [IW-1:0] cand;
    logic          found;

    // Walk ptr+1, ptr+2, ... wrapping, and take the first asserted request.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            j    = (32'(ptr) + k) % N;
            cand = IW'(j);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/hamming_enc_sched.sv
// Round-robin scheduler sharing one 4-to-7 Hamming encoder between NREQ producers.
//   clk, reset            - clock and synchronous active-low reset
//   req_valid/bits/ready  - per-requester nibble handshake (ready is one-hot)
//   out_valid/ready       - codeword handshake toward the consumer
//   out_code, out_id      - encoder codeword and originating requester index
//   enc_reset/active/bits - encoder control: reset, load strobe, nibble
//   enc_byte, enc_ready   - encoder codeword and its valid flag
//   err, drop             - pulses on capture failure / word discarded after retry
module hamming_enc_sched
    import hamming_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned IDW       = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [DATA_W*NREQ-1:0] req_bits,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      out_code,
    output logic [IDW-1:0]         out_id,
    output logic                   enc_reset,
    output logic                   enc_active,
    output logic [DATA_W-1:0]      enc_bits,
    input  logic [CODE_W-1:0]      enc_byte,
    input  logic                   enc_ready,
    output logic                   err,
    output logic                   drop
);

    state_t              state_q, state_d;
    logic [2:0]          word_cnt_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      gnt_id_q;
    logic [DATA_W-1:0]   nibble_q;
    logic                pending_q;
    logic                retried_q;
    logic                out_valid_q;
    logic [CODE_W-1:0]   out_code_q;
    logic [IDW-1:0]      out_id_q;
    logic                err_q;
    logic                drop_q;

    logic                burst_done;
    logic                arb_en;
    logic [NREQ-1:0]     arb_gnt;
    logic [IDW-1:0]      arb_idx;
    logic                grant;

    // The encoder only takes BURST_LEN words per reset, so stop granting at the limit.
    assign burst_done = (word_cnt_q == 3'(BURST_LEN));
    assign arb_en     = (state_q == IDLE) && !burst_done;
    assign grant      = |arb_gnt;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign req_ready  = arb_gnt;
    assign enc_reset  = (state_q == ENC_RST);
    assign enc_active = (state_q == ISSUE);
    assign enc_bits   = enc_active ? nibble_q : '0;
    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign out_id     = out_id_q;
    assign err        = err_q;
    assign drop       = drop_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ENC_RST: state_d = pending_q ? ISSUE : IDLE;
            IDLE: begin
                if (burst_done)  state_d = ENC_RST;
                else if (grant)  state_d = ISSUE;
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                if (enc_ready)       state_d = DELIVER;
                else if (!retried_q) state_d = ENC_RST;
                else                 state_d = IDLE;
            end
            DELIVER: if (out_ready) state_d = IDLE;
            default: state_d = ENC_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ENC_RST;
            word_cnt_q  <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
            gnt_id_q    <= '0;
            nibble_q    <= '0;
            pending_q   <= 1'b0;
            retried_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_id_q    <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            case (state_q)
                ENC_RST: word_cnt_q <= '0;
                IDLE: begin
                    if (grant) begin
                        nibble_q  <= req_bits[arb_idx*DATA_W +: DATA_W];
                        gnt_id_q  <= arb_idx;
                        retried_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    word_cnt_q <= word_cnt_q + 3'd1;
                    pending_q  <= 1'b0;
                end
                CAPTURE: begin
                    if (enc_ready) begin
                        out_code_q  <= enc_byte;
                        out_id_q    <= gnt_id_q;
                        out_valid_q <= 1'b1;
                    end else if (!retried_q) begin
                        // Reset the encoder and re-issue the same latched nibble once.
                        err_q     <= 1'b1;
                        pending_q <= 1'b1;
                        retried_q <= 1'b1;
                    end else begin
                        err_q    <= 1'b1;
                        drop_q   <= 1'b1;
                        rr_ptr_q <= gnt_id_q;
                    end
                end
                DELIVER: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        rr_ptr_q    <= gnt_id_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
